// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, bit functions, working-variable struct and FSM states.
//   K     : 64 round constants
//   IV    : initial hash value, H0 in the most significant word
//   work_t: working variables a..h, a in the most significant word
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } work_t;

    localparam work_t IV = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic work_t add_work(input work_t x, input work_t y);
        return '{x.a + y.a, x.b + y.b, x.c + y.c, x.d + y.d,
                 x.e + y.e, x.f + y.f, x.g + y.g, x.h + y.h};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   cur: working variables before the round
//   k  : round constant K[t]
//   w  : schedule word W[t]
//   nxt: working variables after the round
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output work_t       nxt
);

    logic [31:0] t1, t2;

    assign t1  = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    assign t2  = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);
    assign nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                   e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};

endmodule

// File: rtl/sha256_block_core.sv
// sha256_block_core: multi-block SHA-256 engine, UNROLL rounds per clock.
//   clk, reset_b      : clock, asynchronous active-low reset
//   block             : pre-padded 512-bit block, W0 in [511:480]
//   block_first/last  : block opens / closes a message
//   block_valid/ready : block handshake, ready only in IDLE
//   digest            : final hash, H0 in [255:224]
//   digest_valid      : digest holds the hash of the latest message
module sha256_block_core
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [511:0] block,
    input  logic         block_first,
    input  logic         block_last,
    input  logic         block_valid,
    output logic         block_ready,
    output logic [255:0] digest,
    output logic         digest_valid
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256_block_core: UNROLL must be 1, 2, 4 or 8");
    end

    state_t      state;
    logic [5:0]  t;
    logic        last;
    logic [31:0] w [0:15];
    work_t       v, h, h_sum;
    work_t       chain [0:UNROLL];
    logic [31:0] ext [0:15+UNROLL];

    // Window extended by UNROLL freshly scheduled words; the next window is ext[UNROLL +: 16].
    always_comb begin
        for (int j = 0; j < 16; j++) ext[j] = w[j];
        for (int j = 16; j < 16 + UNROLL; j++)
            ext[j] = ssig1(ext[j-2]) + ext[j-7] + ssig0(ext[j-15]) + ext[j-16];
    end

    assign chain[0] = v;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        sha256_round u_round (
            .cur (chain[g]),
            .k   (K[t + 6'(g)]),
            .w   (w[g]),
            .nxt (chain[g+1])
        );
    end

    assign h_sum = add_work(h, v);

    // t wraps to 0 after the final ROUND edge, so six bits suffice.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state        <= IDLE;
            block_ready  <= 1'b1;
            digest_valid <= 1'b0;
            digest       <= '0;
            h            <= IV;
            v            <= '0;
            t            <= '0;
            last         <= 1'b0;
            for (int j = 0; j < 16; j++) w[j] <= '0;
        end else begin
            case (state)
                IDLE: if (block_valid) begin
                    for (int j = 0; j < 16; j++) w[j] <= block[511-32*j -: 32];
                    v            <= block_first ? IV : h;
                    h            <= block_first ? IV : h;
                    last         <= block_last;
                    t            <= '0;
                    digest_valid <= 1'b0;
                    block_ready  <= 1'b0;
                    state        <= ROUND;
                end
                ROUND: begin
                    v <= chain[UNROLL];
                    for (int j = 0; j < 16; j++) w[j] <= ext[j+UNROLL];
                    t <= t + 6'(UNROLL);
                    if (t == 6'(64 - UNROLL)) state <= FINAL;
                end
                FINAL: begin
                    h <= h_sum;
                    if (last) begin
                        digest       <= h_sum;
                        digest_valid <= 1'b1;
                    end
                    block_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_core.sv
// tb_sha256_block_core: directed vectors for sha256_block_core at UNROLL = 1, 2, 4, 8.
module tb_sha256_block_core;

    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_TWO1  = {256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
                                        192'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                                        64'h8000000000000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        logic [511:0] blk;
        logic         f;
        logic         l;
        logic [255:0] dig;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_b = 1'b0;
    logic [511:0] blk = '0;
    logic         bf = 1'b0;
    logic         bl = 1'b0;
    logic [3:0]   bv = '0;
    logic [3:0]   rdy;
    logic [3:0]   dv;
    logic [255:0] dig [4];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_block_core #(.UNROLL(1 << g)) dut (
            .clk          (clk),
            .reset_b      (reset_b),
            .block        (blk),
            .block_first  (bf),
            .block_last   (bl),
            .block_valid  (bv[g]),
            .block_ready  (rdy[g]),
            .digest       (dig[g]),
            .digest_valid (dv[g])
        );
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Waits for ready, presents one block for one edge, then counts edges
    // until digest_valid first rises (dl) and until ready returns (rl).
    task automatic send(input int u, input logic [511:0] b, input logic f, input logic l,
                        output int rl, output int dl);
        int k;
        k  = 0;
        rl = 0;
        dl = 0;
        while (!rdy[u] && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        blk   = b;
        bf    = f;
        bl    = l;
        bv[u] = 1'b1;
        @(posedge clk);
        #1;
        bv[u] = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (dv[u] && dl == 0) dl = c;
            if (rdy[u]) begin
                rl = c;
                break;
            end
        end
    endtask

    initial begin
        vec_t tbl [6];
        int   rl, dl, k;
        tbl[0] = '{B_EMPTY, 1'b1, 1'b1, D_EMPTY};
        tbl[1] = '{B_ABC,   1'b1, 1'b1, D_ABC};
        tbl[2] = '{B_TWO1,  1'b1, 1'b0, '0};
        tbl[3] = '{B_TWO2,  1'b0, 1'b1, D_TWO};
        tbl[4] = '{B_ABC,   1'b1, 1'b1, D_ABC};
        tbl[5] = '{B_EMPTY, 1'b1, 1'b1, D_EMPTY};

        #12;
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("u%0d_rst_ready", u), 256'(rdy[u]), 256'(1));
            chk($sformatf("u%0d_rst_dv", u), 256'(dv[u]), 256'(0));
            chk($sformatf("u%0d_rst_digest", u), dig[u], '0);
        end
        reset_b = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            send(0, tbl[i].blk, tbl[i].f, tbl[i].l, rl, dl);
            chk($sformatf("row%0d_ready_lat", i), 256'(rl), 256'(65));
            chk($sformatf("row%0d_dv", i), 256'(dv[0]), 256'(tbl[i].l));
            if (tbl[i].l) begin
                chk($sformatf("row%0d_dv_lat", i), 256'(dl), 256'(65));
                chk($sformatf("row%0d_digest", i), dig[0], tbl[i].dig);
            end
        end

        for (int u = 0; u < 4; u++) begin
            send(u, B_ABC, 1'b1, 1'b1, rl, dl);
            chk($sformatf("u%0d_dv_lat", u), 256'(dl), 256'((64 >> u) + 1));
            chk($sformatf("u%0d_ready_lat", u), 256'(rl), 256'((64 >> u) + 1));
            chk($sformatf("u%0d_digest", u), dig[u], D_ABC);
        end

        // Backpressure: valid stays high with a second block while the first is hashed.
        blk   = B_ABC;
        bf    = 1'b1;
        bl    = 1'b1;
        bv[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_low", 256'(rdy[0]), 256'(0));
        blk = B_EMPTY;
        k   = 0;
        while (!rdy[0] && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp_ready_lat", 256'(k), 256'(65));
        chk("bp_first_digest", dig[0], D_ABC);
        chk("bp_first_dv", 256'(dv[0]), 256'(1));
        @(posedge clk);
        #1;
        bv[0] = 1'b0;
        chk("bp_second_taken", 256'(rdy[0]), 256'(0));
        chk("bp_second_dv_clear", 256'(dv[0]), 256'(0));
        k = 0;
        while (!rdy[0] && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp_second_digest", dig[0], D_EMPTY);

        // Reset asserted 20 rounds into a message.
        blk   = B_TWO1;
        bf    = 1'b1;
        bl    = 1'b0;
        bv[0] = 1'b1;
        @(posedge clk);
        #1;
        bv[0] = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        chk("mid_ready_low", 256'(rdy[0]), 256'(0));
        reset_b = 1'b0;
        #1;
        chk("arst_ready", 256'(rdy[0]), 256'(1));
        chk("arst_dv", 256'(dv[0]), 256'(0));
        chk("arst_digest", dig[0], '0);
        #2;
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        send(0, B_ABC, 1'b1, 1'b1, rl, dl);
        chk("post_rst_dv_lat", 256'(dl), 256'(65));
        chk("post_rst_digest", dig[0], D_ABC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
